// File: rtl/mmio_gpio_hub.sv
// mmio_gpio_hub: memory-mapped GPIO block with NUM_PORTS channels of WIDTH bits.
// Each channel has four word registers at BASE+4k: OUT, IN, EDGE (W1C) and MASK.
// Edge capture, MASK and irq exist only when MMIO_GPIO_IRQ_EN is defined.
// Without that macro, EDGE and MASK read as 0 and irq is tied low.
module mmio_gpio_hub #(
    parameter logic [15:0] BASE      = 16'hC000,
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned WIDTH     = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [15:0]                  addr,
    input  logic                         we,
    input  logic                         re,
    input  logic [15:0]                  wdata,
    output logic [15:0]                  rdata,
    output logic                         rvalid,
    input  logic [NUM_PORTS*WIDTH-1:0]   gpio_in,
    output logic [NUM_PORTS*WIDTH-1:0]   gpio_out,
    output logic                         irq
);

    localparam int unsigned NB = NUM_PORTS * WIDTH;

    logic [15:0]          w_off;
    logic                 w_hit;
    logic [NUM_PORTS-1:0] w_chsel;
    logic [15:0]          w_rd_mux;
    logic                 w_unused_bits;

    logic [NB-1:0]        r_out;
    logic [NB-1:0]        r_sync1;
    logic [NB-1:0]        r_sync2;
    logic [15:0]          r_rdata;
    logic                 r_rvalid;

`ifdef MMIO_GPIO_IRQ_EN
    logic [NB-1:0]        r_sync3;
    logic [NB-1:0]        r_edge;
    logic [NB-1:0]        r_mask;
    logic                 r_irq;
    logic [NB-1:0]        w_rise;
    logic [NB-1:0]        w_clr;
`endif

    // Offset from BASE; wraps for addresses below BASE, so one compare covers both sides.
    assign w_off = addr - BASE;
    assign w_hit = ({16'd0, w_off} < (4 * NUM_PORTS));

    assign w_unused_bits = &{1'b0, wdata};

    // One-hot channel select for a hitting address.
    always_comb begin
        w_chsel = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            w_chsel[k] = w_hit && (w_off[15:2] == 14'(k));
        end
    end

    // Read data multiplexer, zero-extended to 16 bits; sampled before any same-cycle write lands.
    always_comb begin
        w_rd_mux = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (w_chsel[k]) begin
                case (w_off[1:0])
                    2'd0: w_rd_mux[WIDTH-1:0] = r_out[k*WIDTH +: WIDTH];
                    2'd1: w_rd_mux[WIDTH-1:0] = r_sync2[k*WIDTH +: WIDTH];
`ifdef MMIO_GPIO_IRQ_EN
                    2'd2: w_rd_mux[WIDTH-1:0] = r_edge[k*WIDTH +: WIDTH];
                    2'd3: w_rd_mux[WIDTH-1:0] = r_mask[k*WIDTH +: WIDTH];
`endif
                    default: ;
                endcase
            end
        end
    end

    // OUT registers: CPU writes drive the LEDs on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                if (we && w_chsel[k] && (w_off[1:0] == 2'd0))
                    r_out[k*WIDTH +: WIDTH] <= wdata[WIDTH-1:0];
            end
        end
    end

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
        end
    end

    // Registered read response: one-cycle rvalid pulse, rdata zero when not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= re && w_hit;
            r_rdata  <= (re && w_hit) ? w_rd_mux : '0;
        end
    end

`ifdef MMIO_GPIO_IRQ_EN
    assign w_rise = r_sync2 & ~r_sync3;

    // W1C clear vector for EDGE writes.
    always_comb begin
        w_clr = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (we && w_chsel[k] && (w_off[1:0] == 2'd2))
                w_clr[k*WIDTH +: WIDTH] = wdata[WIDTH-1:0];
        end
    end

    // Edge capture: a new rising edge wins over a same-cycle W1C clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync3 <= '0;
            r_edge  <= '0;
        end else begin
            r_sync3 <= r_sync2;
            r_edge  <= (r_edge & ~w_clr) | w_rise;
        end
    end

    // MASK registers, plain read/write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                if (we && w_chsel[k] && (w_off[1:0] == 2'd3))
                    r_mask[k*WIDTH +: WIDTH] <= wdata[WIDTH-1:0];
            end
        end
    end

    // Level interrupt, registered one cycle behind the EDGE/MASK state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_irq <= 1'b0;
        else        r_irq <= |(r_edge & r_mask);
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    assign gpio_out = r_out;
    assign rdata    = r_rdata;
    assign rvalid   = r_rvalid;

endmodule

// File: tb/tb_mmio_gpio_hub.sv
// Scoreboard bench for mmio_gpio_hub (NUM_PORTS=2, WIDTH=10, BASE=16'hC000).
// Expected EDGE/MASK/irq values depend on whether MMIO_GPIO_IRQ_EN is defined.
module tb_mmio_gpio_hub;

    localparam int NP = 2;
    localparam int W  = 10;
`ifdef MMIO_GPIO_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [15:0]      addr = 16'h0000;
    logic             we = 1'b0;
    logic             re = 1'b0;
    logic [15:0]      wdata = 16'h0000;
    logic [15:0]      rdata;
    logic             rvalid;
    logic [NP*W-1:0]  gpio_in = '0;
    logic [NP*W-1:0]  gpio_out;
    logic             irq;

    typedef struct {
        logic [15:0] data;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mmio_gpio_hub #(
        .BASE      (16'hC000),
        .NUM_PORTS (NP),
        .WIDTH     (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .we       (we),
        .re       (re),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w, input logic r);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = w;
        re    = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            addr  = 16'h0000;
            wdata = 16'h0000;
            we    = 1'b0;
            re    = 1'b0;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        drive(a, d, 1'b1, 1'b0);
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e, input string nm);
        exp_t x;
        drive(a, 16'h0000, 1'b0, 1'b1);
        x.data = e;
        x.name = nm;
        exp_q.push_back(x);
    endtask

    // Monitor: compares every presented read response against the scoreboard.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (rvalid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_rvalid actual rdata=%h required no response", rdata);
                end else begin
                    x = exp_q.pop_front();
                    if (rdata !== x.data) begin
                        errors++;
                        $display("FAIL %s actual=%h required=%h", x.name, rdata, x.data);
                    end
                end
            end else begin
                checks++;
                if (rdata !== 16'h0000) begin
                    errors++;
                    $display("FAIL rdata_idle actual=%h required=0000", rdata);
                end
            end
        end
    end

    initial begin
        // Reset state
        idle(2);
        chk("reset_gpio_out", 32'(gpio_out), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_rvalid", 32'(rvalid), 32'h0);
        rst_n = 1'b1;
        idle(1);

        // OUT writes and channel isolation
        wr(16'hC000, 16'h03FF);
        idle(1);
        chk("out_ch0", 32'(gpio_out), 32'h003FF);
        wr(16'hC004, 16'hFEAA);
        idle(1);
        chk("out_ch1", 32'(gpio_out), 32'hAABFF);

        // Back-to-back reads
        rd(16'hC000, 16'h03FF, "rd_out0");
        rd(16'hC004, 16'h02AA, "rd_out1");
        rd(16'hC001, 16'h0000, "rd_in0_idle");
        rd(16'hC003, 16'h0000, "rd_mask0_reset");
        wr(16'hC001, 16'hFFFF);
        rd(16'hC001, 16'h0000, "rd_in0_after_write");
        idle(1);

        // Input synchronisation and edge capture on bit 3
        gpio_in[3] = 1'b1;
        idle(1);
        rd(16'hC001, 16'h0008, "rd_in0_bit3");
        rd(16'hC002, IRQ ? 16'h0008 : 16'h0000, "rd_edge0_bit3");
        idle(1);
        chk("irq_masked_off", 32'(irq), 32'h0);

        // Mask enables the interrupt one cycle after the mask update
        wr(16'hC003, 16'h0008);
        idle(1);
        chk("irq_latency", 32'(irq), 32'h0);
        idle(1);
        chk("irq_set", 32'(irq), 32'(IRQ));
        rd(16'hC003, IRQ ? 16'h0008 : 16'h0000, "rd_mask0");

        // W1C clear drops irq one cycle after the EDGE clear
        wr(16'hC002, 16'h0008);
        idle(1);
        chk("irq_hold_after_clr", 32'(irq), 32'(IRQ));
        idle(1);
        chk("irq_cleared", 32'(irq), 32'h0);
        rd(16'hC002, 16'h0000, "rd_edge0_cleared");

        // Clear collides with a fresh rising edge: set wins
        idle(1);
        gpio_in[3] = 1'b0;
        idle(4);
        gpio_in[3] = 1'b1;
        idle(1);
        wr(16'hC002, 16'h0008);
        idle(1);
        rd(16'hC002, IRQ ? 16'h0008 : 16'h0000, "rd_edge0_set_priority");
        idle(2);
        chk("irq_after_priority", 32'(irq), 32'(IRQ));

        // Misses: no response, no state change
        drive(16'hC008, 16'h0000, 1'b0, 1'b1);
        drive(16'hC008, 16'hFFFF, 1'b1, 1'b0);
        drive(16'hBFFF, 16'hFFFF, 1'b1, 1'b1);
        rd(16'hC000, 16'h03FF, "rd_out0_after_miss");
        rd(16'hC004, 16'h02AA, "rd_out1_after_miss");
        idle(1);
        chk("out_after_miss", 32'(gpio_out), 32'hAABFF);

        // Simultaneous write and read returns the old value
        drive(16'hC000, 16'h0155, 1'b1, 1'b1);
        begin
            exp_t x;
            x.data = 16'h03FF;
            x.name = "rd_we_re_old";
            exp_q.push_back(x);
        end
        idle(1);
        chk("out_we_re_new", 32'(gpio_out), 32'hAA955);
        rd(16'hC000, 16'h0155, "rd_we_re_new");

        // Asynchronous reset while rvalid is high and a read is pending
        drive(16'hC000, 16'h0000, 1'b0, 1'b1);
        chk("pre_reset_irq", 32'(irq), 32'(IRQ));
        chk("pre_reset_rvalid", 32'(rvalid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_gpio_out", 32'(gpio_out), 32'h0);
        chk("async_reset_irq", 32'(irq), 32'h0);
        chk("async_reset_rvalid", 32'(rvalid), 32'h0);
        idle(2);
        rst_n = 1'b1;

        // Input still high after reset: exactly one new edge
        idle(4);
        rd(16'hC002, IRQ ? 16'h0008 : 16'h0000, "rd_edge0_post_reset");
        idle(1);
        chk("irq_post_reset_masked", 32'(irq), 32'h0);
        wr(16'hC002, 16'h0008);
        idle(4);
        rd(16'hC002, 16'h0000, "rd_edge0_single_edge");
        rd(16'hC000, 16'h0000, "rd_out0_post_reset");
        rd(16'hC003, 16'h0000, "rd_mask0_post_reset");
        rd(16'hC001, 16'h0008, "rd_in0_post_reset");
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_gpio_hub.md
MMIO_GPIO_HUB -- requirements
Module: mmio_gpio_hub

Interface
REQ-001 SHALL have parameter BASE, default 16'hC000, word address of port 0 register block.
REQ-002 SHALL have parameter NUM_PORTS, default 2, number of GPIO channels (1..8).
REQ-003 SHALL have parameter WIDTH, default 10, bits per channel (1..16).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port addr  input  16  CPU word address.
REQ-007 SHALL have port we  input  1  write strobe, single cycle.
REQ-008 SHALL have port re  input  1  read strobe, single cycle.
REQ-009 SHALL have port wdata  input  16  write data.
REQ-010 SHALL have port rdata  output  16  registered read data.
REQ-011 SHALL have port rvalid  output  1  one-cycle pulse qualifying rdata.
REQ-012 SHALL have port gpio_in  input  NUM_PORTS*WIDTH  asynchronous inputs (switches); channel k at bits [k*WIDTH +: WIDTH].
REQ-013 SHALL have port gpio_out  output  NUM_PORTS*WIDTH  registered outputs (LEDs), same packing.
REQ-014 SHALL have port irq  output  1  level interrupt request.

Function
REQ-015 SHALL decode channel k registers at BASE+4k+r: r=0 OUT (R/W), r=1 IN (RO), r=2 EDGE (R/W1C), r=3 MASK (R/W).
REQ-016 SHALL treat addresses outside BASE..BASE+4*NUM_PORTS-1 as misses: no state change, no rvalid, rdata held at 0.
REQ-017 SHALL write wdata[WIDTH-1:0] into OUT/MASK on the cycle we is high and addr hits; wdata bits above WIDTH ignored; writes to IN ignored.
REQ-018 SHALL drive gpio_out from OUT registers, visible the cycle after the write edge.
REQ-019 SHALL synchronise each gpio_in bit through two flops; IN reads return the second-stage value.
REQ-020 SHALL detect rising edges by comparing second and third sync stages, setting the matching EDGE bit.
REQ-021 SHALL clear EDGE bits where a write to EDGE has wdata bit = 1; bits written 0 unchanged.
REQ-022 SHALL give set priority when a rising edge and a W1C clear hit the same EDGE bit in one cycle (bit remains 1).
REQ-023 SHALL assert irq whenever any (EDGE & MASK) bit of any channel is 1, registered, one cycle after the causing update.
REQ-024 SHALL return read data one cycle after re on a hit, zero-extended to 16 bits, with rvalid high that cycle only; rdata returns to 0 when rvalid low.
REQ-025 SHALL, when we and re assert together on the same hit address, perform the write and return the pre-write value.
REQ-026 SHALL accept back-to-back accesses every cycle with no stall.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear OUT, EDGE, MASK, all sync flops, rdata, rvalid, irq to 0.
REQ-028 SHALL not report edges on the first cycles after reset release for inputs already high (sync stages start at 0, so a high input SHALL produce exactly one edge).
REQ-029 SHALL abort any pending read on reset mid-operation; no rvalid issued after reset release for pre-reset reads.

Configuration
REQ-030 SHALL compile edge capture, MASK and irq only when macro MMIO_GPIO_IRQ_EN is defined.
REQ-031 SHALL, without MMIO_GPIO_IRQ_EN, read EDGE and MASK as 0, ignore writes to them, tie irq to 0, and omit the third sync stage; OUT/IN behaviour unchanged.

Verification
REQ-032 SHALL cover: write 16'h03FF to 16'hC000 -> gpio_out[9:0]=10'h3FF next cycle; write to 16'hC004 -> gpio_out[19:10] updated, channel 0 unchanged.
REQ-033 SHALL cover: gpio_in[3] 0->1 -> IN at 16'hC001 reads 16'h0008 within 3 cycles of the change; EDGE at 16'hC002 reads 16'h0008.
REQ-034 SHALL cover: MASK=16'h0008, edge on bit 3 -> irq=1; write 16'h0008 to 16'hC002 -> irq=0 one cycle after the EDGE clear.
REQ-035 SHALL cover: W1C of bit 3 in the same cycle as a new rising edge on bit 3 -> EDGE bit 3 stays 1.
REQ-036 SHALL cover: read 16'hC008 with NUM_PORTS=2 -> no rvalid, rdata 0, no state change; we+re on 16'hC000 -> old value returned, new value stored.
REQ-037 SHALL cover: rst_n pulsed low while OUT=16'h0155 and irq=1 -> gpio_out=0, irq=0, rvalid=0 immediately, without waiting for a clock edge.
